// File: rtl/tlv5619_sample_sequencer.sv
// tlv5619_sample_sequencer: FIFO-buffered, rate-paced CS/WE/LDAC sequencer for the TLV5619 DAC.
// Ports: ACLK/ARESETN; control (enable, flush, rate_div, ldac_auto, pd_req, clr_status);
//   sample stream (s_data, s_valid, s_ready); DAC pins (dac_d, dac_cs_n, dac_we_n,
//   dac_ldac_n, dac_pd_n); status (busy, fifo_level, underrun_cnt, rate_err).
module tlv5619_sample_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 2,
  parameter int WE_CYC     = 3,
  parameter int HOLD_CYC   = 2,
  parameter int LDAC_CYC   = 2
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          enable,
  input  logic                          flush,
  input  logic [15:0]                   rate_div,
  input  logic                          ldac_auto,
  input  logic                          pd_req,
  input  logic [11:0]                   s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [11:0]                   dac_d,
  output logic                          dac_cs_n,
  output logic                          dac_we_n,
  output logic                          dac_ldac_n,
  output logic                          dac_pd_n,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   underrun_cnt,
  output logic                          rate_err,
  input  logic                          clr_status
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [15:0] SETUP_LD = 16'(SETUP_CYC - 1);
  localparam logic [15:0] WE_LD    = 16'(WE_CYC - 1);
  localparam logic [15:0] HOLD_LD  = 16'(HOLD_CYC - 1);
  localparam logic [15:0] LDAC_LD  = 16'(LDAC_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WRITE,
    S_HOLD,
    S_LDAC
  } state_t;

  state_t state;

  // ---------------- sample FIFO ----------------
  logic [11:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_nx;
  logic          push;
  logic          pop;
  logic          fifo_empty;

  assign push       = s_valid && s_ready;
  assign fifo_empty = (fifo_level == '0);

  always_comb begin
    level_nx = fifo_level;
    if (flush)
      level_nx = '0;
    else if (push && !pop)
      level_nx = fifo_level + 1'b1;
    else if (pop && !push)
      level_nx = fifo_level - 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (push && !flush)
      mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      s_ready    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
      end
      fifo_level <= level_nx;
      // ready tracks the level being written, so it drops the cycle the FIFO fills
      s_ready    <= (level_nx != LW'(FIFO_DEPTH));
    end
  end

  // ---------------- rate timer ----------------
  // armed stays low for the first cycle out of reset so the counter
  // starts from a freshly loaded rate_div rather than from zero.
  logic [15:0] tmr_cnt;
  logic        tmr_armed;
  logic        tick;

  assign tick = enable && tmr_armed && (tmr_cnt == 16'd0);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      tmr_cnt   <= '0;
      tmr_armed <= 1'b0;
    end else if (!enable || !tmr_armed) begin
      tmr_cnt   <= rate_div;
      tmr_armed <= 1'b1;
    end else if (tmr_cnt == 16'd0) begin
      tmr_cnt <= rate_div;
    end else begin
      tmr_cnt <= tmr_cnt - 16'd1;
    end
  end

  // ---------------- strobe FSM ----------------
  logic [15:0] ph_cnt;
  logic        auto_q;
  logic        idle;

  assign idle = (state == S_IDLE);
  assign pop  = tick && idle && !fifo_empty;
  assign busy = !idle;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state      <= S_IDLE;
      ph_cnt     <= '0;
      auto_q     <= 1'b1;
      dac_d      <= '0;
      dac_cs_n   <= 1'b1;
      dac_we_n   <= 1'b1;
      dac_ldac_n <= 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          // transparent mode keeps LDAC low whenever idle
          dac_ldac_n <= ldac_auto;
          if (pop) begin
            dac_d    <= mem[rd_ptr];
            dac_cs_n <= 1'b0;
            auto_q   <= ldac_auto;
            ph_cnt   <= SETUP_LD;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (ph_cnt == 16'd0) begin
            dac_we_n <= 1'b0;
            ph_cnt   <= WE_LD;
            state    <= S_WRITE;
          end else begin
            ph_cnt <= ph_cnt - 16'd1;
          end
        end
        S_WRITE: begin
          if (ph_cnt == 16'd0) begin
            dac_we_n <= 1'b1;
            ph_cnt   <= HOLD_LD;
            state    <= S_HOLD;
          end else begin
            ph_cnt <= ph_cnt - 16'd1;
          end
        end
        S_HOLD: begin
          if (ph_cnt == 16'd0) begin
            dac_cs_n <= 1'b1;
            if (auto_q) begin
              dac_ldac_n <= 1'b0;
              ph_cnt     <= LDAC_LD;
              state      <= S_LDAC;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            ph_cnt <= ph_cnt - 16'd1;
          end
        end
        S_LDAC: begin
          if (ph_cnt == 16'd0) begin
            dac_ldac_n <= ldac_auto;
            state      <= S_IDLE;
          end else begin
            ph_cnt <= ph_cnt - 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------- status and power-down ----------------
  logic underrun_inc;
  logic rate_viol;

  assign underrun_inc = tick && idle && fifo_empty;
  assign rate_viol    = tick && !idle;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      underrun_cnt <= '0;
      rate_err     <= 1'b0;
      dac_pd_n     <= 1'b0;
    end else begin
      dac_pd_n <= ~pd_req;
      // an underrun in the clearing cycle is still counted
      if (clr_status)
        underrun_cnt <= underrun_inc ? 16'd1 : 16'd0;
      else if (underrun_inc && underrun_cnt != 16'hFFFF)
        underrun_cnt <= underrun_cnt + 16'd1;
      if (rate_viol)
        rate_err <= 1'b1;
      else if (clr_status)
        rate_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tlv5619_sample_sequencer.sv
// tb_tlv5619_sample_sequencer: directed bench for tlv5619_sample_sequencer.
// Covers reset, basic write, underrun, rate violation, transparent mode, backpressure/flush.
module tb_tlv5619_sample_sequencer;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] rate_div = 16'd19;
  logic        ldac_auto = 1'b1;
  logic        pd_req = 1'b0;
  logic [11:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        clr_status = 1'b0;
  logic        s_ready;
  logic [11:0] dac_d;
  logic        dac_cs_n;
  logic        dac_we_n;
  logic        dac_ldac_n;
  logic        dac_pd_n;
  logic        busy;
  logic [2:0]  fifo_level;
  logic [15:0] underrun_cnt;
  logic        rate_err;

  int checks = 0;
  int errors = 0;

  tlv5619_sample_sequencer dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .flush(flush),
    .rate_div(rate_div), .ldac_auto(ldac_auto), .pd_req(pd_req),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .dac_d(dac_d), .dac_cs_n(dac_cs_n), .dac_we_n(dac_we_n),
    .dac_ldac_n(dac_ldac_n), .dac_pd_n(dac_pd_n), .busy(busy),
    .fifo_level(fifo_level), .underrun_cnt(underrun_cnt),
    .rate_err(rate_err), .clr_status(clr_status)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  logic        cs_t   [256];
  logic        we_t   [256];
  logic        ldac_t [256];
  logic        rerr_t [256];
  logic [11:0] d_t    [256];
  int n_cap;
  int falls [8];
  int nfalls;
  int cs_len, we_off, we_len, ldac_off, ldac_len;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    enable = 1'b0; flush = 1'b0; rate_div = 16'd19;
    ldac_auto = 1'b1; pd_req = 1'b0; s_valid = 1'b0;
    s_data = '0; clr_status = 1'b0;
    repeat (3) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    step();
  endtask

  task automatic push(input logic [11:0] d);
    s_valid = 1'b1;
    s_data = d;
    step();
    s_valid = 1'b0;
  endtask

  task automatic capture(input int n);
    logic prev;
    prev = dac_cs_n;
    n_cap = n;
    nfalls = 0;
    for (int i = 0; i < n; i++) begin
      step();
      cs_t[i] = dac_cs_n;
      we_t[i] = dac_we_n;
      ldac_t[i] = dac_ldac_n;
      rerr_t[i] = rate_err;
      d_t[i] = dac_d;
      if (prev && !dac_cs_n && nfalls < 8) begin
        falls[nfalls] = i;
        nfalls++;
      end
      prev = dac_cs_n;
    end
  endtask

  task automatic measure(input int f);
    int j;
    cs_len = 0;
    j = f;
    while (j < n_cap && cs_t[j] == 1'b0) begin cs_len++; j++; end
    we_off = -1;
    for (int i = f; i < n_cap && i < f + 16; i++)
      if (we_t[i] == 1'b0 && we_off < 0) we_off = i - f;
    we_len = 0;
    if (we_off >= 0) begin
      j = f + we_off;
      while (j < n_cap && we_t[j] == 1'b0) begin we_len++; j++; end
    end
    ldac_off = -1;
    for (int i = f; i < n_cap && i < f + 16; i++)
      if (ldac_t[i] == 1'b0 && ldac_off < 0) ldac_off = i - f;
    ldac_len = 0;
    if (ldac_off >= 0) begin
      j = f + ldac_off;
      while (j < n_cap && ldac_t[j] == 1'b0) begin ldac_len++; j++; end
    end
  endtask

  task automatic test_reset();
    int t;
    ARESETN = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    checks++;
    if ({dac_cs_n, dac_we_n, dac_ldac_n, dac_pd_n} !== 4'b1110) begin
      errors++;
      $display("FAIL rst_pins got %b exp 1110", {dac_cs_n, dac_we_n, dac_ldac_n, dac_pd_n});
    end
    checks++;
    if ({s_ready, busy, rate_err, fifo_level, underrun_cnt, dac_d} !== '0) begin
      errors++;
      $display("FAIL rst_status rdy %b busy %b lvl %0d ur %0d d %h exp all 0",
               s_ready, busy, fifo_level, underrun_cnt, dac_d);
    end
    ARESETN = 1'b1;
    step();
    checks++;
    if ({s_ready, dac_pd_n} !== 2'b11) begin
      errors++;
      $display("FAIL rst_release rdy/pd got %b exp 11", {s_ready, dac_pd_n});
    end
    rate_div = 16'd3;
    push(12'h5A5);
    push(12'h5A6);
    enable = 1'b1;
    t = 0;
    while (dac_we_n !== 1'b0 && t < 40) begin step(); t++; end
    checks++;
    if (t >= 40) begin
      errors++;
      $display("FAIL rst_reach_write timed out got we_n %b exp 0", dac_we_n);
    end
    #2 ARESETN = 1'b0;
    #1;
    checks++;
    if ({dac_cs_n, dac_we_n, dac_ldac_n, dac_pd_n} !== 4'b1110) begin
      errors++;
      $display("FAIL rst_midwrite_pins got %b exp 1110", {dac_cs_n, dac_we_n, dac_ldac_n, dac_pd_n});
    end
    checks++;
    if ({fifo_level, busy, s_ready, dac_d} !== '0) begin
      errors++;
      $display("FAIL rst_midwrite_state lvl %0d busy %b rdy %b d %h exp 0", fifo_level, busy, s_ready, dac_d);
    end
    do_reset();
  endtask

  task automatic test_basic_write();
    logic [11:0] exp_d [3];
    exp_d[0] = 12'h123; exp_d[1] = 12'hABC; exp_d[2] = 12'hFFF;
    do_reset();
    rate_div = 16'd19;
    push(12'h123); push(12'hABC); push(12'hFFF);
    checks++;
    if (fifo_level !== 3'd3) begin
      errors++;
      $display("FAIL basic_level got %0d exp 3", fifo_level);
    end
    enable = 1'b1;
    capture(80);
    enable = 1'b0;
    checks++;
    if (nfalls !== 3) begin
      errors++;
      $display("FAIL basic_nseq got %0d exp 3", nfalls);
    end
    for (int k = 0; k < 3 && k < nfalls; k++) begin
      measure(falls[k]);
      checks++;
      if ({cs_len, we_off, we_len, ldac_off, ldac_len} !== {32'd7, 32'd2, 32'd3, 32'd7, 32'd2}) begin
        errors++;
        $display("FAIL basic_shape%0d cs %0d weoff %0d we %0d ldoff %0d ld %0d exp 7 2 3 7 2",
                 k, cs_len, we_off, we_len, ldac_off, ldac_len);
      end
      checks++;
      if (d_t[falls[k]] !== exp_d[k]) begin
        errors++;
        $display("FAIL basic_data%0d got %h exp %h", k, d_t[falls[k]], exp_d[k]);
      end
      if (k > 0) begin
        checks++;
        if (falls[k] - falls[k-1] !== 20) begin
          errors++;
          $display("FAIL basic_period%0d got %0d exp 20", k, falls[k] - falls[k-1]);
        end
      end
    end
  endtask

  task automatic test_underrun();
    int lows;
    do_reset();
    rate_div = 16'd9;
    step();
    enable = 1'b1;
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (!dac_cs_n || !dac_we_n || !dac_ldac_n) lows++;
    end
    enable = 1'b0;
    checks++;
    if (underrun_cnt !== 16'd5) begin
      errors++;
      $display("FAIL underrun_count got %0d exp 5", underrun_cnt);
    end
    checks++;
    if (lows !== 0) begin
      errors++;
      $display("FAIL underrun_strobes got %0d exp 0", lows);
    end
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    checks++;
    if (underrun_cnt !== 16'd0) begin
      errors++;
      $display("FAIL underrun_clear got %0d exp 0", underrun_cnt);
    end
  endtask

  task automatic test_rate_violation();
    logic [11:0] exp_d [4];
    exp_d[0] = 12'h001; exp_d[1] = 12'h202; exp_d[2] = 12'h403; exp_d[3] = 12'h804;
    do_reset();
    rate_div = 16'd4;
    for (int i = 0; i < 4; i++) push(exp_d[i]);
    checks++;
    if ({fifo_level, s_ready} !== {3'd4, 1'b0}) begin
      errors++;
      $display("FAIL rate_full lvl %0d rdy %b exp 4 0", fifo_level, s_ready);
    end
    enable = 1'b1;
    capture(60);
    enable = 1'b0;
    checks++;
    if (nfalls !== 4) begin
      errors++;
      $display("FAIL rate_nseq got %0d exp 4", nfalls);
    end
    if (nfalls > 0) begin
      checks++;
      if ({rerr_t[falls[0]+4], rerr_t[falls[0]+5]} !== 2'b01) begin
        errors++;
        $display("FAIL rate_err_onset got %b exp 01", {rerr_t[falls[0]+4], rerr_t[falls[0]+5]});
      end
    end
    for (int k = 0; k < 4 && k < nfalls; k++) begin
      measure(falls[k]);
      checks++;
      if ({cs_len, we_off, we_len, ldac_len} !== {32'd7, 32'd2, 32'd3, 32'd2}) begin
        errors++;
        $display("FAIL rate_shape%0d cs %0d weoff %0d we %0d ld %0d exp 7 2 3 2",
                 k, cs_len, we_off, we_len, ldac_len);
      end
      checks++;
      if (d_t[falls[k]] !== exp_d[k]) begin
        errors++;
        $display("FAIL rate_data%0d got %h exp %h", k, d_t[falls[k]], exp_d[k]);
      end
      if (k > 0) begin
        checks++;
        if (falls[k] - falls[k-1] !== 10) begin
          errors++;
          $display("FAIL rate_period%0d got %0d exp 10", k, falls[k] - falls[k-1]);
        end
      end
    end
    checks++;
    if (rate_err !== 1'b1) begin
      errors++;
      $display("FAIL rate_err_sticky got %b exp 1", rate_err);
    end
  endtask

  task automatic test_transparent();
    int highs;
    logic [11:0] exp_d [4];
    exp_d[0] = 12'h7F0; exp_d[1] = 12'h0F7; exp_d[2] = 12'h555; exp_d[3] = 12'hAAA;
    do_reset();
    ldac_auto = 1'b0;
    pd_req = 1'b1;
    rate_div = 16'd7;
    for (int i = 0; i < 4; i++) push(exp_d[i]);
    checks++;
    if ({dac_ldac_n, dac_pd_n} !== 2'b00) begin
      errors++;
      $display("FAIL transp_idle ldac/pd got %b exp 00", {dac_ldac_n, dac_pd_n});
    end
    enable = 1'b1;
    capture(50);
    enable = 1'b0;
    highs = 0;
    for (int i = 0; i < n_cap; i++) if (ldac_t[i] !== 1'b0) highs++;
    checks++;
    if (highs !== 0) begin
      errors++;
      $display("FAIL transp_ldac high cycles got %0d exp 0", highs);
    end
    checks++;
    if (nfalls !== 4) begin
      errors++;
      $display("FAIL transp_nseq got %0d exp 4", nfalls);
    end
    for (int k = 0; k < 4 && k < nfalls; k++) begin
      measure(falls[k]);
      checks++;
      if ({cs_len, we_off, we_len} !== {32'd7, 32'd2, 32'd3}) begin
        errors++;
        $display("FAIL transp_shape%0d cs %0d weoff %0d we %0d exp 7 2 3", k, cs_len, we_off, we_len);
      end
      checks++;
      if (d_t[falls[k]] !== exp_d[k]) begin
        errors++;
        $display("FAIL transp_data%0d got %h exp %h", k, d_t[falls[k]], exp_d[k]);
      end
      if (k > 0) begin
        checks++;
        if (falls[k] - falls[k-1] !== 8) begin
          errors++;
          $display("FAIL transp_period%0d got %0d exp 8", k, falls[k] - falls[k-1]);
        end
      end
    end
    checks++;
    if ({rate_err, dac_pd_n} !== 2'b00) begin
      errors++;
      $display("FAIL transp_status rerr/pd got %b exp 00", {rate_err, dac_pd_n});
    end
  endtask

  task automatic test_backpressure();
    int acc;
    int lows;
    do_reset();
    rate_div = 16'd19;
    acc = 0;
    s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_data = 12'(12'h010 + i);
      if (s_ready) acc++;
      step();
      checks++;
      if (s_ready !== (fifo_level != 3'd4)) begin
        errors++;
        $display("FAIL bp_ready%0d got %b at level %0d", i, s_ready, fifo_level);
      end
    end
    checks++;
    if ({acc, fifo_level, s_ready} !== {32'd4, 3'd4, 1'b0}) begin
      errors++;
      $display("FAIL bp_full acc %0d lvl %0d rdy %b exp 4 4 0", acc, fifo_level, s_ready);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    s_valid = 1'b0;
    checks++;
    if ({fifo_level, s_ready} !== {3'd0, 1'b1}) begin
      errors++;
      $display("FAIL bp_flush lvl %0d rdy %b exp 0 1", fifo_level, s_ready);
    end
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!dac_cs_n || !dac_we_n) lows++;
    end
    checks++;
    if (lows !== 0) begin
      errors++;
      $display("FAIL bp_no_strobe got %0d exp 0", lows);
    end
    push(12'h777);
    enable = 1'b1;
    capture(30);
    enable = 1'b0;
    checks++;
    if (nfalls !== 1 || d_t[falls[0]] !== 12'h777) begin
      errors++;
      $display("FAIL bp_after_flush nseq %0d d %h exp 1 777", nfalls, d_t[falls[0]]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_underrun();
    test_rate_violation();
    test_transparent();
    test_backpressure();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlv5619_sample_sequencer.md
# tlv5619_sample_sequencer

Paced sample sequencer for the TLV5619 12-bit parallel DAC. It sits between the AXI4-Lite register block of the tlv5619_driver IP and the DAC pins. It buffers 12-bit samples in a small FIFO, releases one sample per programmable sample-rate tick, and generates the CS/WE/LDAC strobe sequence with configurable cycle widths. It also reports underruns and rate violations.

## Interface
Parameters:
- FIFO_DEPTH, 4: sample FIFO depth; power of two, minimum 2.
- SETUP_CYC, 2: cycles that CS is low with data valid before WE falls; minimum 1.
- WE_CYC, 3: WE low pulse width, in cycles; minimum 1.
- HOLD_CYC, 2: cycles that CS stays low and data is held after WE rises; minimum 1.
- LDAC_CYC, 2: LDAC low pulse width in auto-LDAC mode; minimum 1.

Ports:
- ACLK  in  1  single clock for the whole block.
- ARESETN  in  1  reset; asynchronous assertion, active-low.
- enable  in  1  runs the rate timer; when low, no ticks are generated.
- flush  in  1  single-cycle pulse that empties the FIFO.
- rate_div  in  16  tick period minus 1, in ACLK cycles.
- ldac_auto  in  1  1: LDAC is pulsed after each write. 0: LDAC is held low (transparent mode).
- pd_req  in  1  1: drives the DAC into power-down.
- s_data  in  12  input sample.
- s_valid  in  1  sample valid.
- s_ready  out  1  asserted when the FIFO is not full.
- dac_d  out  12  DAC data bus.
- dac_cs_n  out  1  DAC chip select.
- dac_we_n  out  1  DAC write strobe.
- dac_ldac_n  out  1  DAC load strobe.
- dac_pd_n  out  1  DAC power-down.
- busy  out  1  asserted when the FSM is not in IDLE.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- underrun_cnt  out  16  saturating count of ticks that found the FIFO empty.
- rate_err  out  1  sticky flag: a tick arrived while the FSM was busy.
- clr_status  in  1  pulse that clears underrun_cnt and rate_err.

## Operation
- **Reset values** (all outputs):
  - dac_d=0, dac_cs_n=1, dac_we_n=1, dac_ldac_n=1, dac_pd_n=0.
  - s_ready=0 while ARESETN is low.
  - busy=0, fifo_level=0, underrun_cnt=0, rate_err=0.
  - FSM in IDLE, timer loaded with rate_div.
- **FIFO:**
  - A write occurs when s_valid && s_ready.
  - The FSM pops one entry on tick acceptance.
  - A simultaneous push and pop leaves the level unchanged.
  - flush sets the level to 0 and wins over a same-cycle push.
- **Rate timer:**
  - While enable=1 it decrements each cycle.
  - At 0 it emits a one-cycle tick and reloads from rate_div.
  - While enable=0 it holds rate_div.
  - rate_div=0 produces a tick every cycle.
- **FSM states:** IDLE → SETUP → WRITE → HOLD → (LDAC if ldac_auto) → IDLE.
  - IDLE, tick, FIFO non-empty: pop, register dac_d, go to SETUP.
  - IDLE, tick, FIFO empty: underrun_cnt increments (saturates at 0xFFFF). Stay in IDLE; dac_d is unchanged.
  - SETUP: cs_n=0 for SETUP_CYC cycles.
  - WRITE: cs_n=0, we_n=0 for WE_CYC cycles.
  - HOLD: cs_n=0, we_n=1 for HOLD_CYC cycles.
  - LDAC: cs_n=1, ldac_n=0 for LDAC_CYC cycles.
- **Tick outside IDLE:** the tick is dropped and rate_err is set. clr_status clears it; a same-cycle set wins over the clear.
- **ldac_auto=0:**
  - dac_ldac_n=0 continuously whenever not in reset.
  - The LDAC state is skipped.
  - ldac_auto is sampled at entry to SETUP.
- **pd_req:**
  - dac_pd_n = ~pd_req, registered.
  - Writes continue while pd_req=1.
- **enable deasserted mid-transfer:** the current sequence completes; no new tick follows.
- **flush during a transfer:** it does not abort the sample already popped.
- **dac_d:** holds its last value until the next pop.

## Timing
- Tick at cycle T (FIFO non-empty): dac_d valid and dac_cs_n=0 from T+1.
- dac_we_n falls at T+1+SETUP_CYC and rises at T+1+SETUP_CYC+WE_CYC.
- dac_cs_n rises at T+1+SETUP_CYC+WE_CYC+HOLD_CYC.
- Auto-LDAC: ldac_n is low for the LDAC_CYC cycles that follow, then the FSM returns to IDLE.
- Minimum sustainable period, in cycles:
  - ldac_auto=1: SETUP+WE+HOLD+LDAC+1 (default 10, i.e. rate_div ≥ 9).
  - ldac_auto=0: the same without LDAC (default 8).
- s_ready = ~full, registered. The FIFO accepts one sample per cycle.
- fifo_level and underrun_cnt update one cycle after the event that changes them.

## Test plan
- **Reset:**
  - Stimulus: assert ARESETN low mid-WRITE.
  - Required: all pins return to reset values immediately (cs_n=1, we_n=1, pd_n=0). FIFO empty.
- **Basic write** (defaults):
  - Stimulus: ldac_auto=1, rate_div=19, push 0x123, 0xABC, 0xFFF; enable.
  - Required: three sequences 20 cycles apart.
  - Each sequence: cs_n low for 7 cycles, we_n low for 3 cycles starting 2 cycles after cs_n falls, ldac_n low for 2 cycles after cs_n rises.
  - dac_d holds 0x123, 0xABC, 0xFFF in that order.
- **Underrun:**
  - Stimulus: enable with an empty FIFO and rate_div=9 for 50 cycles.
  - Required: underrun_cnt=5, no strobes. clr_status returns it to 0.
- **Rate violation:**
  - Stimulus: ldac_auto=1, rate_div=4, FIFO full of 4 samples.
  - Required: rate_err=1 after the first dropped tick. Each sequence still completes fully, with WE 3 cycles wide.
- **Transparent mode:**
  - Stimulus: ldac_auto=0, rate_div=7, 4 samples.
  - Required: ldac_n stays at 0 and back-to-back sequences run every 8 cycles. rate_err stays at 0.
- **Backpressure and flush:**
  - Stimulus: push 6 samples with enable=0.
  - Required: s_ready deasserts at fifo_level=4 and the last 2 samples are held off.
  - Then flush → fifo_level=0, s_ready=1, no strobe issued.
